reservation_station_gen2: RTL and testbench
===========================================

# reservation_station_gen2

Parametrised reservation station for the out-of-order core. It sits between rename/dispatch and the execution unit. Each dispatched ALU or load operation is held with its two operands, and each operand is either a captured value or a physical-register tag. Operands wake up from up to `CDB_N` common-data-bus broadcasts, and the oldest entry whose operands are both ready issues once per cycle. A whole-station flush supports branch-mispredict recovery.

## Interface
Parameters:
- `DEPTH`, 8: number of entries; power of two, ≥2.
- `DATA_W`, 32: operand width.
- `TAG_W`, 6: physical-register tag width.
- `CDB_N`, 2: number of CDB broadcast channels.
- `CTL_W`, 5: opcode/ALU-control width; carried through unmodified.

Ports:
- Clock and reset:
  - `clk` in, 1: sole clock.
  - `rst` in, 1: reset, synchronous and active-high.
- Dispatch:
  - `disp_valid` in, 1: dispatch request.
  - `disp_ready` out, 1: a free slot exists.
  - `disp_ctl` in, `CTL_W`: operation control.
  - `disp_dst_tag` in, `TAG_W`: destination physical tag.
  - `disp_j_rdy` / `disp_k_rdy` in, 1: operand j/k value already available.
  - `disp_j_val` / `disp_k_val` in, `DATA_W`: operand values; meaningful only when the matching `rdy` is 1.
  - `disp_j_tag` / `disp_k_tag` in, `TAG_W`: producer tags; meaningful only when the matching `rdy` is 0.
- CDB:
  - `cdb_valid` in, `CDB_N`: per-channel broadcast valid.
  - `cdb_tag` in, `CDB_N*TAG_W`: channel c occupies bits `[c*TAG_W +: TAG_W]`.
  - `cdb_data` in, `CDB_N*DATA_W`: packed the same way.
- Issue:
  - `iss_valid` out, 1: an issuable entry is presented.
  - `iss_ready` in, 1: the execution unit accepts it.
  - `iss_ctl` out, `CTL_W`; `iss_vj` / `iss_vk` out, `DATA_W`; `iss_dst_tag` out, `TAG_W`: the issuing entry's contents.
- Control and status:
  - `flush` in, 1: discard all entries.
  - `occupancy` out, `$clog2(DEPTH)+1`: number of valid entries.

## Operation
- Per-entry state: `valid`, `ctl`, `dst_tag`, and for each of j and k a `rdy` bit, a `val`, and a `tag`. An age matrix orders the entries: `older[i][j]` = 1 means entry j was allocated before entry i.
- **Dispatch:**
  - Accepted when `disp_valid & disp_ready & !flush`.
  - The lowest-index free slot is written.
  - The new slot's row of `older` is loaded with the current `valid` vector; column s is cleared in every other row.
- **Same-cycle bypass:** if an incoming operand has `rdy`=0 and its tag matches a valid CDB channel in the same cycle, the entry stores that channel's data with `rdy`=1.
- **Wakeup:** every valid entry whose operand has `rdy`=0 and whose tag matches a valid CDB channel captures the data and sets `rdy`=1.
- If several channels carry the same tag, the lowest channel index wins.
- **Issue select:**
  - An entry is ready when `valid & j.rdy & k.rdy`.
  - The selected entry is the ready entry i for which no other ready entry j has `older[i][j]`=1, i.e. the oldest ready entry.
  - `iss_valid` = (any entry ready) `& !flush`.
  - The issue outputs are combinational from registered state.
  - On `iss_valid & iss_ready`, the selected slot's `valid` clears at the clock edge.
- `disp_ready` = (`occupancy` < `DEPTH`). It does not credit a same-cycle issue.
- **Flush:** at the next edge all `valid` bits and the age matrix clear. Any dispatch or issue in the same cycle is discarded.
- **Reset:** all `valid` clear, the age matrix clears, `occupancy`=0, `disp_ready`=1, `iss_valid`=0. Reset has priority over flush, dispatch and issue.

## Timing
- Dispatch with both operands ready: the entry can issue in the cycle after the dispatch edge. Minimum dispatch-to-issue latency is 1 cycle.
- A CDB capture at edge N makes the entry issuable in cycle N+1.
- No entry issues in the same cycle as the broadcast that wakes it.
- Dispatch and issue may fall in the same cycle. `occupancy` then stays unchanged.
- The newly allocated slot is never the issuing slot.
- When full, `disp_valid` is ignored, nothing is written, and `disp_ready` stays 0 until the cycle after an issue.
- If `iss_ready` stays 0, the selection may change only when an older entry becomes ready. Issue outputs are not required to be held stable.

## Structure
- Shared package `rs_pkg`: the `rs_entry_t` struct (`valid`, `ctl`, `dst_tag`, and a j/k operand sub-struct `rs_opnd_t` with `rdy`/`val`/`tag`).
- Sub-module `rs_oldest_picker` (parameter `DEPTH`):
  - inputs: the ready vector and the age matrix;
  - outputs: a one-hot grant and `any`.

## Test plan
- **Reset, then basic issue:**
  - Hold `rst`=1 for 2 cycles → `occupancy`=0, `disp_ready`=1, `iss_valid`=0.
  - Dispatch ctl=3, j=5, k=7 (both ready), dst=12 → next cycle `iss_vj`=5, `iss_vk`=7, `iss_dst_tag`=12.
- **Wakeup:**
  - Dispatch with j tag=9 (not ready) and k ready.
  - Broadcast tag 9, data 0xAB on channel 1 at cycle t → `iss_valid` rises at t+1 with `iss_vj`=0xAB.
- **Same-cycle bypass:** dispatch j tag=4 while channel 0 broadcasts tag 4, data 0x11 → issues the next cycle with `iss_vj`=0x11.
- **Age order:**
  - Dispatch A (j waits on tag 2), then B (ready), with `iss_ready`=0.
  - Wake tag 2 → A issues before B even though B was ready first.
- **Full/stall:**
  - Fill 8 entries with `iss_ready`=0 → `disp_ready`=0 and a 9th dispatch is dropped.
  - One issue → `disp_ready`=1 the next cycle and `occupancy`=7.
- **Flush:** with 5 entries held, assert `flush` together with `disp_valid` and `iss_ready` → next cycle `occupancy`=0, no issue handshake occurred, and the dispatched op is absent.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared types for the reservation station: per-entry storage layout.
// The struct field widths set the datapath; the top-level width parameters default to them.
package rs_pkg;

  localparam int RS_DATA_W = 32;
  localparam int RS_TAG_W  = 6;
  localparam int RS_CTL_W  = 5;

  typedef struct packed {
    logic                 rdy;
    logic [RS_DATA_W-1:0] val;
    logic [RS_TAG_W-1:0]  tag;
  } rs_opnd_t;

  typedef struct packed {
    logic                valid;
    logic [RS_CTL_W-1:0] ctl;
    logic [RS_TAG_W-1:0] dst_tag;
    rs_opnd_t            j;
    rs_opnd_t            k;
  } rs_entry_t;

endpackage

// File: rtl/rs_oldest_picker.sv
// Age-matrix arbiter: grants the ready entry that has no older ready entry.
module rs_oldest_picker #(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]            i_ready,
  input  logic [DEPTH-1:0][DEPTH-1:0] i_older,
  output logic [DEPTH-1:0]            o_grant,
  output logic                        o_any
);

  // Row i of i_older lists the entries allocated before entry i.
  always_comb begin
    o_grant = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_grant[i] = i_ready[i] & ~(|(i_ready & i_older[i]));
    end
  end

  assign o_any = |i_ready;

endmodule

// File: rtl/reservation_station_gen2.sv
// Reservation station: holds dispatched ops, wakes operands from the CDB,
// and issues the oldest ready entry each cycle.
module reservation_station_gen2
  import rs_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = RS_DATA_W,
  parameter int TAG_W  = RS_TAG_W,
  parameter int CDB_N  = 2,
  parameter int CTL_W  = RS_CTL_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    disp_valid,
  output logic                    disp_ready,
  input  logic [CTL_W-1:0]        disp_ctl,
  input  logic [TAG_W-1:0]        disp_dst_tag,
  input  logic                    disp_j_rdy,
  input  logic                    disp_k_rdy,
  input  logic [DATA_W-1:0]       disp_j_val,
  input  logic [DATA_W-1:0]       disp_k_val,
  input  logic [TAG_W-1:0]        disp_j_tag,
  input  logic [TAG_W-1:0]        disp_k_tag,
  input  logic [CDB_N-1:0]        cdb_valid,
  input  logic [CDB_N*TAG_W-1:0]  cdb_tag,
  input  logic [CDB_N*DATA_W-1:0] cdb_data,
  output logic                    iss_valid,
  input  logic                    iss_ready,
  output logic [CTL_W-1:0]        iss_ctl,
  output logic [DATA_W-1:0]       iss_vj,
  output logic [DATA_W-1:0]       iss_vk,
  output logic [TAG_W-1:0]        iss_dst_tag,
  input  logic                    flush,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = IDX_W + 1;

  rs_entry_t                   r_ent [DEPTH];
  logic [DEPTH-1:0][DEPTH-1:0] r_older;
  logic [OCC_W-1:0]            r_occ;

  logic [DEPTH-1:0] w_valid_vec;
  logic [DEPTH-1:0] w_rdy_vec;
  logic [DEPTH-1:0] w_free_oh;
  logic [DEPTH-1:0] w_grant;
  logic             w_any;
  logic [IDX_W-1:0] w_iss_idx;
  logic             w_disp_acc;
  logic             w_iss_acc;
  rs_entry_t        w_new;

  // Scanning channels high to low lets the lowest matching channel win.
  function automatic rs_opnd_t f_capture(
    input rs_opnd_t                op,
    input logic [CDB_N-1:0]        v,
    input logic [CDB_N*TAG_W-1:0]  t,
    input logic [CDB_N*DATA_W-1:0] d
  );
    rs_opnd_t res;
    res = op;
    if (!op.rdy) begin
      for (int c = CDB_N - 1; c >= 0; c--) begin
        if (v[c] && (t[c*TAG_W +: TAG_W] == op.tag)) begin
          res.rdy = 1'b1;
          res.val = d[c*DATA_W +: DATA_W];
        end
      end
    end
    return res;
  endfunction

  // Per-entry status vectors, lowest free slot and grant encoding.
  always_comb begin
    w_iss_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_valid_vec[i] = r_ent[i].valid;
      w_rdy_vec[i]   = r_ent[i].valid & r_ent[i].j.rdy & r_ent[i].k.rdy;
      w_iss_idx      = w_iss_idx | (w_grant[i] ? IDX_W'(i) : {IDX_W{1'b0}});
    end
    w_free_oh = ~w_valid_vec & (~(~w_valid_vec) + DEPTH'(1));
  end

  rs_oldest_picker #(.DEPTH(DEPTH)) u_picker (
    .i_ready (w_rdy_vec),
    .i_older (r_older),
    .o_grant (w_grant),
    .o_any   (w_any)
  );

  assign disp_ready = (r_occ < OCC_W'(DEPTH));
  assign w_disp_acc = disp_valid & disp_ready & ~flush;
  assign iss_valid  = w_any & ~flush;
  assign w_iss_acc  = iss_valid & iss_ready;

  // Incoming entry with same-cycle CDB bypass applied to waiting operands.
  always_comb begin
    w_new         = '0;
    w_new.valid   = 1'b1;
    w_new.ctl     = disp_ctl;
    w_new.dst_tag = disp_dst_tag;
    w_new.j       = f_capture('{rdy: disp_j_rdy, val: disp_j_val, tag: disp_j_tag},
                              cdb_valid, cdb_tag, cdb_data);
    w_new.k       = f_capture('{rdy: disp_k_rdy, val: disp_k_val, tag: disp_k_tag},
                              cdb_valid, cdb_tag, cdb_data);
  end

  assign iss_ctl     = r_ent[w_iss_idx].ctl;
  assign iss_vj      = r_ent[w_iss_idx].j.val;
  assign iss_vk      = r_ent[w_iss_idx].k.val;
  assign iss_dst_tag = r_ent[w_iss_idx].dst_tag;
  assign occupancy   = r_occ;

  // Entry storage, age matrix and occupancy; reset beats flush beats normal update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ent[i] <= '0;
      end
      r_older <= '0;
      r_occ   <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ent[i].valid <= 1'b0;
      end
      r_older <= '0;
      r_occ   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_disp_acc && w_free_oh[i]) begin
          r_ent[i]   <= w_new;
          r_older[i] <= w_valid_vec;
        end else begin
          r_ent[i].j     <= f_capture(r_ent[i].j, cdb_valid, cdb_tag, cdb_data);
          r_ent[i].k     <= f_capture(r_ent[i].k, cdb_valid, cdb_tag, cdb_data);
          r_ent[i].valid <= r_ent[i].valid & ~(w_iss_acc & w_grant[i]);
          r_older[i]     <= r_older[i] & ~(w_disp_acc ? w_free_oh : {DEPTH{1'b0}});
        end
      end
      r_occ <= r_occ + OCC_W'(w_disp_acc) - OCC_W'(w_iss_acc);
    end
  end

endmodule

// File: tb/tb_reservation_station_gen2.sv
// Scoreboard bench: expected issue packets are queued at dispatch and checked at each handshake.
module tb_reservation_station_gen2;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 6;
  localparam int CDB_N  = 2;
  localparam int CTL_W  = 5;

  typedef struct packed {
    logic [CTL_W-1:0]  ctl;
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] vk;
    logic [TAG_W-1:0]  dst;
  } exp_t;

  logic                    clk;
  logic                    rst;
  logic                    disp_valid;
  logic                    disp_ready;
  logic [CTL_W-1:0]        disp_ctl;
  logic [TAG_W-1:0]        disp_dst_tag;
  logic                    disp_j_rdy;
  logic                    disp_k_rdy;
  logic [DATA_W-1:0]       disp_j_val;
  logic [DATA_W-1:0]       disp_k_val;
  logic [TAG_W-1:0]        disp_j_tag;
  logic [TAG_W-1:0]        disp_k_tag;
  logic [CDB_N-1:0]        cdb_valid;
  logic [CDB_N*TAG_W-1:0]  cdb_tag;
  logic [CDB_N*DATA_W-1:0] cdb_data;
  logic                    iss_valid;
  logic                    iss_ready;
  logic [CTL_W-1:0]        iss_ctl;
  logic [DATA_W-1:0]       iss_vj;
  logic [DATA_W-1:0]       iss_vk;
  logic [TAG_W-1:0]        iss_dst_tag;
  logic                    flush;
  logic [$clog2(DEPTH):0]  occupancy;

  int   n_checks;
  int   n_fails;
  exp_t sb[$];

  reservation_station_gen2 #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .CDB_N(CDB_N), .CTL_W(CTL_W)
  ) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_ctl(disp_ctl),
    .disp_dst_tag(disp_dst_tag), .disp_j_rdy(disp_j_rdy), .disp_k_rdy(disp_k_rdy),
    .disp_j_val(disp_j_val), .disp_k_val(disp_k_val),
    .disp_j_tag(disp_j_tag), .disp_k_tag(disp_k_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_ctl(iss_ctl),
    .iss_vj(iss_vj), .iss_vk(iss_vk), .iss_dst_tag(iss_dst_tag),
    .flush(flush), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive_disp(input logic [CTL_W-1:0] ctl,
                            input logic jr, input logic [DATA_W-1:0] jv, input logic [TAG_W-1:0] jt,
                            input logic kr, input logic [DATA_W-1:0] kv, input logic [TAG_W-1:0] kt,
                            input logic [TAG_W-1:0] dst);
    disp_valid   = 1'b1;
    disp_ctl     = ctl;
    disp_j_rdy   = jr;
    disp_j_val   = jv;
    disp_j_tag   = jt;
    disp_k_rdy   = kr;
    disp_k_val   = kv;
    disp_k_tag   = kt;
    disp_dst_tag = dst;
  endtask

  task automatic idle_disp();
    disp_valid = 1'b0;
    disp_ctl   = '0;
    disp_j_rdy = 1'b0;
    disp_k_rdy = 1'b0;
    disp_j_val = '0;
    disp_k_val = '0;
    disp_j_tag = '0;
    disp_k_tag = '0;
    disp_dst_tag = '0;
  endtask

  task automatic set_cdb(input int ch, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    cdb_valid[ch]               = 1'b1;
    cdb_tag[ch*TAG_W +: TAG_W]  = t;
    cdb_data[ch*DATA_W +: DATA_W] = d;
  endtask

  task automatic clr_cdb();
    cdb_valid = '0;
    cdb_tag   = '0;
    cdb_data  = '0;
  endtask

  // Issue monitor: every handshake must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && iss_valid && iss_ready) begin
      if (sb.size() == 0) begin
        check_val("unexpected_issue", 64'(iss_valid), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val("iss_ctl", 64'(iss_ctl), 64'(e.ctl));
        check_val("iss_vj", 64'(iss_vj), 64'(e.vj));
        check_val("iss_vk", 64'(iss_vk), 64'(e.vk));
        check_val("iss_dst_tag", 64'(iss_dst_tag), 64'(e.dst));
      end
    end
  end

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    iss_ready = 1'b0;
    idle_disp();
    clr_cdb();
    cyc();
    cyc();
    rst = 1'b0;
    mid();
    check_val("rst_occupancy", 64'(occupancy), 64'd0);
    check_val("rst_disp_ready", 64'(disp_ready), 64'd1);
    check_val("rst_iss_valid", 64'(iss_valid), 64'd0);

    // Basic: both operands ready, issues one cycle after dispatch.
    cyc();
    iss_ready = 1'b1;
    drive_disp(5'd3, 1'b1, 32'd5, 6'd0, 1'b1, 32'd7, 6'd0, 6'd12);
    sb.push_back('{ctl: 5'd3, vj: 32'd5, vk: 32'd7, dst: 6'd12});
    cyc();
    idle_disp();
    mid();
    check_val("basic_iss_valid", 64'(iss_valid), 64'd1);
    check_val("basic_occ", 64'(occupancy), 64'd1);
    cyc();
    mid();
    check_val("basic_drained", 64'(occupancy), 64'd0);

    // Wakeup on channel 1; not issuable in the broadcast cycle.
    cyc();
    drive_disp(5'd1, 1'b0, 32'd0, 6'd9, 1'b1, 32'h22, 6'd0, 6'd20);
    sb.push_back('{ctl: 5'd1, vj: 32'hAB, vk: 32'h22, dst: 6'd20});
    cyc();
    idle_disp();
    set_cdb(1, 6'd9, 32'hAB);
    mid();
    check_val("wake_same_cycle_no_issue", 64'(iss_valid), 64'd0);
    cyc();
    clr_cdb();
    mid();
    check_val("wake_next_cycle_issue", 64'(iss_valid), 64'd1);
    cyc();

    // k waits; both channels carry the tag, channel 0 data wins.
    drive_disp(5'd2, 1'b1, 32'h01, 6'd0, 1'b0, 32'd0, 6'd13, 6'd21);
    sb.push_back('{ctl: 5'd2, vj: 32'h01, vk: 32'hC0, dst: 6'd21});
    cyc();
    idle_disp();
    set_cdb(0, 6'd13, 32'hC0);
    set_cdb(1, 6'd13, 32'hC1);
    cyc();
    clr_cdb();
    mid();
    check_val("dual_cdb_issue", 64'(iss_valid), 64'd1);
    cyc();

    // Same-cycle bypass at dispatch.
    drive_disp(5'd4, 1'b0, 32'd0, 6'd4, 1'b1, 32'h33, 6'd0, 6'd22);
    set_cdb(0, 6'd4, 32'h11);
    sb.push_back('{ctl: 5'd4, vj: 32'h11, vk: 32'h33, dst: 6'd22});
    cyc();
    idle_disp();
    clr_cdb();
    mid();
    check_val("bypass_issue", 64'(iss_valid), 64'd1);
    cyc();

    // Age order: A waits, B ready; after wakeup A must be selected first.
    iss_ready = 1'b0;
    drive_disp(5'd6, 1'b0, 32'd0, 6'd2, 1'b1, 32'h44, 6'd0, 6'd30);
    sb.push_back('{ctl: 5'd6, vj: 32'h77, vk: 32'h44, dst: 6'd30});
    cyc();
    drive_disp(5'd7, 1'b1, 32'h55, 6'd0, 1'b1, 32'h66, 6'd0, 6'd31);
    sb.push_back('{ctl: 5'd7, vj: 32'h55, vk: 32'h66, dst: 6'd31});
    cyc();
    idle_disp();
    set_cdb(0, 6'd2, 32'h77);
    mid();
    check_val("age_only_b_ready", 64'(iss_dst_tag), 64'd31);
    cyc();
    clr_cdb();
    iss_ready = 1'b1;
    mid();
    check_val("age_oldest_first", 64'(iss_dst_tag), 64'd30);
    check_val("age_occ", 64'(occupancy), 64'd2);
    cyc();
    cyc();
    iss_ready = 1'b0;
    mid();
    check_val("age_drained", 64'(occupancy), 64'd0);

    // Fill to capacity; a ninth dispatch must be dropped.
    cyc();
    for (int i = 0; i < DEPTH; i++) begin
      drive_disp(CTL_W'(i), 1'b1, 32'h100 + 32'(i), 6'd0, 1'b1, 32'h200 + 32'(i), 6'd0, 6'd40 + 6'(i));
      sb.push_back('{ctl: CTL_W'(i), vj: 32'h100 + 32'(i), vk: 32'h200 + 32'(i), dst: 6'd40 + 6'(i)});
      cyc();
    end
    drive_disp(5'd31, 1'b1, 32'hDEAD, 6'd0, 1'b1, 32'hBEEF, 6'd0, 6'd63);
    mid();
    check_val("full_occ", 64'(occupancy), 64'd8);
    check_val("full_disp_ready", 64'(disp_ready), 64'd0);
    cyc();
    idle_disp();
    mid();
    check_val("full_drop_occ", 64'(occupancy), 64'd8);
    cyc();
    iss_ready = 1'b1;
    mid();
    check_val("full_no_issue_credit", 64'(disp_ready), 64'd0);
    cyc();
    iss_ready = 1'b0;
    mid();
    check_val("after_issue_disp_ready", 64'(disp_ready), 64'd1);
    check_val("after_issue_occ", 64'(occupancy), 64'd7);
    cyc();
    drive_disp(5'h15, 1'b1, 32'h3AB, 6'd0, 1'b1, 32'h3CD, 6'd0, 6'd55);
    sb.push_back('{ctl: 5'h15, vj: 32'h3AB, vk: 32'h3CD, dst: 6'd55});
    iss_ready = 1'b1;
    cyc();
    idle_disp();
    mid();
    check_val("disp_iss_same_cycle_occ", 64'(occupancy), 64'd7);
    repeat (8) cyc();
    mid();
    check_val("full_drained_iss_valid", 64'(iss_valid), 64'd0);
    check_val("full_drained_occ", 64'(occupancy), 64'd0);
    check_val("sb_empty_after_full", 64'(sb.size()), 64'd0);

    // Flush with 5 held entries plus a concurrent dispatch and issue request.
    cyc();
    iss_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_disp(5'd9, 1'b1, 32'(i), 6'd0, 1'b1, 32'(i), 6'd0, 6'd1 + 6'(i));
      cyc();
    end
    flush = 1'b1;
    iss_ready = 1'b1;
    drive_disp(5'd10, 1'b1, 32'h50, 6'd0, 1'b1, 32'h51, 6'd0, 6'd50);
    mid();
    check_val("flush_cycle_no_issue", 64'(iss_valid), 64'd0);
    check_val("flush_cycle_occ", 64'(occupancy), 64'd5);
    cyc();
    flush = 1'b0;
    idle_disp();
    mid();
    check_val("flush_occ", 64'(occupancy), 64'd0);
    check_val("flush_iss_valid", 64'(iss_valid), 64'd0);
    check_val("flush_disp_ready", 64'(disp_ready), 64'd1);
    repeat (3) cyc();
    mid();
    check_val("flush_dispatch_absent", 64'(iss_valid), 64'd0);
    check_val("sb_empty_end", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
